fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction fetch stage of the 5-stage RV64 pipeline; sits directly upstream of decode.
//  Owns the PC register and next-PC selection (sequential, BTB-predicted, execute redirect).
//  Runs a single-outstanding request/response handshake to the instruction cache.
//  Contains the F/D pipeline register (stall/flush) that drives instruction, PC, PC+4
//  and prediction metadata into decode.
// PARAMETERS
//  ADDR_WIDTH  64          PC / memory address width
//  INSTR_WIDTH 32          instruction width
//  RESET_PC    64'h0000_0000  PC value loaded on reset
//  NOP_INSTR   32'h0000_0013  bubble instruction (addi x0,x0,0)
// PORTS
//  i_clk                in  1   clock, rising edge
//  i_arst               in  1   asynchronous reset, active-low (asserted when 0)
//  i_stall_fetch        in  1   hazard unit: hold PC and issue no new request
//  i_stall_dec          in  1   hazard unit: hold F/D register contents
//  i_flush_dec          in  1   load bubble into F/D register
//  i_redirect           in  1   execute: mispredict/jump resolution, take i_redirect_pc
//  i_redirect_pc        in  AW  corrected next PC
//  i_pred_taken         in  1   BTB lookup on o_imem_addr: predicted taken
//  i_pred_target        in  AW  BTB predicted target
//  i_pred_way           in  2   BTB hit way
//  o_imem_req           out 1   request valid; address stable until accepted
//  o_imem_addr          out AW  fetch address (= PC)
//  i_imem_ack           in  1   cache accepted request this cycle
//  i_imem_valid         in  1   response data valid (>=1 cycle after ack)
//  i_imem_rdata         in  IW  fetched instruction
//  o_instruction        out IW  F/D: instruction to decode
//  o_pc                 out AW  F/D: PC of instruction
//  o_pc_plus4           out AW  F/D: PC+4
//  o_pc_target_pred     out AW  F/D: predicted target
//  o_btb_way            out 2   F/D: BTB way
//  o_branch_pred_taken  out 1   F/D: prediction
//  o_valid              out 1   F/D: slot holds a real instruction
// BEHAVIOUR
//  Reset (i_arst=0, async): PC=RESET_PC, state=S_REQ, o_imem_req=0 while in reset;
//   F/D: instruction=NOP_INSTR, pc/pc_plus4/target=0, way=0, taken=0, valid=0.
//  FSM: S_REQ, S_WAIT, S_HOLD, S_KILL.
//   S_REQ: o_imem_req=!i_stall_fetch; on ack -> S_WAIT, latching BTB outputs for this PC.
//   S_WAIT: on valid & !i_stall_dec -> deliver to F/D, PC<=next, -> S_REQ;
//     on valid & i_stall_dec -> capture into hold reg -> S_HOLD.
//   S_HOLD: when !i_stall_dec -> deliver hold reg, PC<=next, -> S_REQ.
//   S_KILL: response outstanding but stale; on valid discard -> S_REQ.
//  Next PC = latched pred_taken ? pred_target : PC+4 (ADDR_WIDTH wrap, no carry-out).
//  Redirect (highest priority, any state): PC<=i_redirect_pc, prediction latch cleared;
//   S_REQ without ack -> stay S_REQ; S_REQ with ack same cycle, or S_WAIT without valid
//   -> S_KILL; S_WAIT with valid, or S_HOLD -> data discarded, -> S_REQ.
//  F/D register, per cycle priority: flush > stall > deliver > bubble.
//   flush: NOP/valid=0 (same cycle as redirect typical); stall: hold all;
//   deliver: load instr/PC/metadata, valid=1; otherwise NOP, valid=0.
//  Latency: ack at cycle N, valid at N+k -> F/D valid at N+k+1; back-to-back issue
//   next request in cycle after delivery (max 1 outstanding).
//  i_stall_fetch only gates new requests; it never cancels an outstanding one.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds o_fetch_cnt (64) counting delivered instructions and
//   o_bubble_cnt (64) counting cycles F/D loads a bubble while not stalled;
//   both reset to 0, wrap at 2^64, not cleared by flush.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  Reset release, 1-cycle-latency cache, no predictions -> addresses 0,4,8..., o_valid=1 from 3rd cycle.
//  BTB taken at PC 0x10 target 0x100 -> next o_imem_addr=0x100; F/D taken=1, target=0x100.
//  Redirect to 0x200 while S_WAIT (no valid) -> returning data dropped, next req addr 0x200, no valid slot.
//  i_stall_dec held 3 cycles as data returns -> F/D frozen; instr delivered once when released, none lost.
//  i_flush_dec with i_stall_dec -> F/D becomes NOP_INSTR, valid=0 (flush wins).
//  Reset asserted mid-S_WAIT -> outputs at reset values immediately; restart at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC/next-PC selection, single-outstanding I-cache handshake, F/D register.
// Optional performance counters are built in when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter int                     ADDR_WIDTH  = 64,
  parameter int                     INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_stall_fetch,
  input  logic                   i_stall_dec,
  input  logic                   i_flush_dec,
  input  logic                   i_redirect,
  input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
  input  logic                   i_pred_taken,
  input  logic [ADDR_WIDTH-1:0]  i_pred_target,
  input  logic [1:0]             i_pred_way,
  output logic                   o_imem_req,
  output logic [ADDR_WIDTH-1:0]  o_imem_addr,
  input  logic                   i_imem_ack,
  input  logic                   i_imem_valid,
  input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
  output logic [INSTR_WIDTH-1:0] o_instruction,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic [ADDR_WIDTH-1:0]  o_pc_plus4,
  output logic [ADDR_WIDTH-1:0]  o_pc_target_pred,
  output logic [1:0]             o_btb_way,
  output logic                   o_branch_pred_taken,
  output logic                   o_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [63:0]            o_fetch_cnt,
  output logic [63:0]            o_bubble_cnt
`endif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_KILL} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic                   pred_taken_q, pred_taken_d;
  logic [ADDR_WIDTH-1:0]  pred_target_q, pred_target_d;
  logic [1:0]             pred_way_q, pred_way_d;
  logic [INSTR_WIDTH-1:0] hold_instr_q, hold_instr_d;

  logic [INSTR_WIDTH-1:0] fd_instr_q, fd_instr_d;
  logic [ADDR_WIDTH-1:0]  fd_pc_q, fd_pc_d;
  logic [ADDR_WIDTH-1:0]  fd_pc_plus4_q, fd_pc_plus4_d;
  logic [ADDR_WIDTH-1:0]  fd_target_q, fd_target_d;
  logic [1:0]             fd_way_q, fd_way_d;
  logic                   fd_taken_q, fd_taken_d;
  logic                   fd_valid_q, fd_valid_d;

  logic [ADDR_WIDTH-1:0]  pc_plus4;
  logic [ADDR_WIDTH-1:0]  next_pc;
  logic                   req_fire;
  logic                   deliver;
  logic [INSTR_WIDTH-1:0] deliver_instr;
  logic                   fd_load_valid;
  logic                   fd_load_bubble;

  // The request is forced low while reset is held, even though the FSM already sits in S_REQ.
  assign o_imem_req  = i_arst && (state_q == S_REQ) && !i_stall_fetch;
  assign o_imem_addr = pc_q;
  assign req_fire    = o_imem_req && i_imem_ack;
  assign pc_plus4    = pc_q + ADDR_WIDTH'(4);
  assign next_pc     = pred_taken_q ? pred_target_q : pc_plus4;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    pred_way_d    = pred_way_q;
    hold_instr_d  = hold_instr_q;
    deliver       = 1'b0;
    deliver_instr = hold_instr_q;

    case (state_q)
      S_REQ: begin
        if (req_fire) begin
          state_d       = S_WAIT;
          pred_taken_d  = i_pred_taken;
          pred_target_d = i_pred_target;
          pred_way_d    = i_pred_way;
        end
      end
      S_WAIT: begin
        if (i_imem_valid) begin
          if (!i_stall_dec) begin
            deliver       = 1'b1;
            deliver_instr = i_imem_rdata;
            pc_d          = next_pc;
            state_d       = S_REQ;
          end else begin
            hold_instr_d = i_imem_rdata;
            state_d      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!i_stall_dec) begin
          deliver = 1'b1;
          pc_d    = next_pc;
          state_d = S_REQ;
        end
      end
      S_KILL: begin
        if (i_imem_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    // A redirect overrides everything; any response already in flight becomes stale.
    if (i_redirect) begin
      pc_d          = i_redirect_pc;
      pred_taken_d  = 1'b0;
      pred_target_d = '0;
      pred_way_d    = '0;
      hold_instr_d  = hold_instr_q;
      deliver       = 1'b0;
      case (state_q)
        S_REQ:   state_d = req_fire ? S_KILL : S_REQ;
        S_WAIT:  state_d = i_imem_valid ? S_REQ : S_KILL;
        S_HOLD:  state_d = S_REQ;
        S_KILL:  state_d = i_imem_valid ? S_REQ : S_KILL;
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      pred_way_q    <= '0;
      hold_instr_q  <= NOP_INSTR;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
      pred_way_q    <= pred_way_d;
      hold_instr_q  <= hold_instr_d;
    end
  end

  // F/D register priority: flush, then stall, then deliver, otherwise a bubble.
  always_comb begin
    fd_instr_d     = fd_instr_q;
    fd_pc_d        = fd_pc_q;
    fd_pc_plus4_d  = fd_pc_plus4_q;
    fd_target_d    = fd_target_q;
    fd_way_d       = fd_way_q;
    fd_taken_d     = fd_taken_q;
    fd_valid_d     = fd_valid_q;
    fd_load_valid  = 1'b0;
    fd_load_bubble = 1'b0;

    if (i_flush_dec) begin
      fd_load_bubble = 1'b1;
    end else if (i_stall_dec) begin
      fd_load_bubble = 1'b0;
    end else if (deliver) begin
      fd_load_valid = 1'b1;
    end else begin
      fd_load_bubble = 1'b1;
    end

    if (fd_load_valid) begin
      fd_instr_d    = deliver_instr;
      fd_pc_d       = pc_q;
      fd_pc_plus4_d = pc_plus4;
      fd_target_d   = pred_target_q;
      fd_way_d      = pred_way_q;
      fd_taken_d    = pred_taken_q;
      fd_valid_d    = 1'b1;
    end else if (fd_load_bubble) begin
      fd_instr_d    = NOP_INSTR;
      fd_pc_d       = '0;
      fd_pc_plus4_d = '0;
      fd_target_d   = '0;
      fd_way_d      = '0;
      fd_taken_d    = 1'b0;
      fd_valid_d    = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      fd_instr_q    <= NOP_INSTR;
      fd_pc_q       <= '0;
      fd_pc_plus4_q <= '0;
      fd_target_q   <= '0;
      fd_way_q      <= '0;
      fd_taken_q    <= 1'b0;
      fd_valid_q    <= 1'b0;
    end else begin
      fd_instr_q    <= fd_instr_d;
      fd_pc_q       <= fd_pc_d;
      fd_pc_plus4_q <= fd_pc_plus4_d;
      fd_target_q   <= fd_target_d;
      fd_way_q      <= fd_way_d;
      fd_taken_q    <= fd_taken_d;
      fd_valid_q    <= fd_valid_d;
    end
  end

  assign o_instruction       = fd_instr_q;
  assign o_pc                = fd_pc_q;
  assign o_pc_plus4          = fd_pc_plus4_q;
  assign o_pc_target_pred    = fd_target_q;
  assign o_btb_way           = fd_way_q;
  assign o_branch_pred_taken = fd_taken_q;
  assign o_valid             = fd_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [63:0] fetch_cnt_q, fetch_cnt_d;
  logic [63:0] bubble_cnt_q, bubble_cnt_d;

  // Bubbles loaded while decode is stalled (flush+stall) are not counted.
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + (fd_load_valid ? 64'd1 : 64'd0);
    bubble_cnt_d = bubble_cnt_q + ((fd_load_bubble && !i_stall_dec) ? 64'd1 : 64'd0);
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign o_fetch_cnt  = fetch_cnt_q;
  assign o_bubble_cnt = bubble_cnt_q;
`else
  logic unused_load;
  assign unused_load = fd_load_valid ^ fd_load_bubble;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: sequential fetch, BTB redirect, execute redirect,
// decode stall/flush, PC wrap and asynchronous reset in the middle of a fetch.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        arstN;
  logic        stallFetch, stallDec, flushDec, redirect;
  logic [63:0] redirectPc;
  logic        predTaken;
  logic [63:0] predTarget;
  logic [1:0]  predWay;
  logic        imemReq;
  logic [63:0] imemAddr;
  logic        imemAck, imemValid;
  logic [31:0] imemRdata;
  logic [31:0] instruction;
  logic [63:0] pcOut, pcPlus4, pcTargetPred;
  logic [1:0]  btbWay;
  logic        branchPredTaken, validOut;
`ifdef FETCH_PERF_CNT_EN
  logic [63:0] fetchCnt, bubbleCnt;
`endif

  int numChecks = 0;
  int numFails  = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .i_clk               (clk),
    .i_arst              (arstN),
    .i_stall_fetch       (stallFetch),
    .i_stall_dec         (stallDec),
    .i_flush_dec         (flushDec),
    .i_redirect          (redirect),
    .i_redirect_pc       (redirectPc),
    .i_pred_taken        (predTaken),
    .i_pred_target       (predTarget),
    .i_pred_way          (predWay),
    .o_imem_req          (imemReq),
    .o_imem_addr         (imemAddr),
    .i_imem_ack          (imemAck),
    .i_imem_valid        (imemValid),
    .i_imem_rdata        (imemRdata),
    .o_instruction       (instruction),
    .o_pc                (pcOut),
    .o_pc_plus4          (pcPlus4),
    .o_pc_target_pred    (pcTargetPred),
    .o_btb_way           (btbWay),
    .o_branch_pred_taken (branchPredTaken),
    .o_valid             (validOut)
`ifdef FETCH_PERF_CNT_EN
    ,
    .o_fetch_cnt         (fetchCnt),
    .o_bubble_cnt        (bubbleCnt)
`endif
  );

  // Counts every comparison and reports any mismatch on a single FAIL line.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives every DUT input for one cycle, then lets combinational outputs settle.
  task automatic applyStimulus(input logic sf, input logic sd, input logic fl, input logic rd,
                               input logic [63:0] rpc, input logic ack, input logic vld,
                               input logic [31:0] data, input logic pt, input logic [63:0] ptgt,
                               input logic [1:0] pw);
    stallFetch = sf;  stallDec  = sd;  flushDec  = fl;  redirect   = rd;
    redirectPc = rpc; imemAck   = ack; imemValid = vld; imemRdata  = data;
    predTaken  = pt;  predTarget = ptgt; predWay = pw;
    #1;
  endtask

  // Advances to just after the next rising edge so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full fetch through a 1-cycle cache: request+ack, response, then F/D contents.
  task automatic fetchOne(input logic [63:0] expAddr, input logic [31:0] data,
                          input logic pt, input logic [63:0] ptgt, input logic [1:0] pw);
    applyStimulus(0, 0, 0, 0, 64'd0, 1, 0, 32'd0, pt, ptgt, pw);
    checkOutput("req", imemReq, 1'b1);
    checkOutput("addr", imemAddr, expAddr);
    tick();
    applyStimulus(0, 0, 0, 0, 64'd0, 0, 1, data, 0, 64'd0, 2'd0);
    checkOutput("req_wait", imemReq, 1'b0);
    checkOutput("valid_wait", validOut, 1'b0);
    tick();
    checkOutput("fd_valid", validOut, 1'b1);
    checkOutput("fd_instr", instruction, data);
    checkOutput("fd_pc", pcOut, expAddr);
    checkOutput("fd_pc4", pcPlus4, expAddr + 64'd4);
    checkOutput("fd_taken", branchPredTaken, pt);
    checkOutput("fd_target", pcTargetPred, ptgt);
    checkOutput("fd_way", btbWay, pw);
  endtask

  // Directed scenario sequence with hand-computed expectations.
  initial begin
    arstN = 1'b0;
    applyStimulus(0, 0, 0, 0, 64'd0, 0, 0, 32'd0, 0, 64'd0, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req", imemReq, 1'b0);
    checkOutput("rst_addr", imemAddr, 64'd0);
    checkOutput("rst_valid", validOut, 1'b0);
    checkOutput("rst_instr", instruction, NOP);
    checkOutput("rst_pc", pcOut, 64'd0);
    arstN = 1'b1;

    $display("[TB] sequential fetch");
    fetchOne(64'h0,  32'h1111_0001, 0, 64'd0, 2'd0);
    fetchOne(64'h4,  32'h1111_0002, 0, 64'd0, 2'd0);
    fetchOne(64'h8,  32'h1111_0003, 0, 64'd0, 2'd0);
    fetchOne(64'hC,  32'h1111_0004, 0, 64'd0, 2'd0);

    $display("[TB] BTB taken at 0x10");
    fetchOne(64'h10, 32'h2222_0001, 1, 64'h100, 2'd2);
    fetchOne(64'h100, 32'h2222_0002, 0, 64'd0, 2'd0);

    $display("[TB] redirect while waiting");
    applyStimulus(0, 0, 0, 0, 64'd0, 1, 0, 32'd0, 0, 64'd0, 2'd0);
    checkOutput("rd_addr", imemAddr, 64'h104);
    tick();
    applyStimulus(0, 0, 1, 1, 64'h200, 0, 0, 32'd0, 0, 64'd0, 2'd0);
    tick();
    checkOutput("kill_req", imemReq, 1'b0);
    checkOutput("kill_valid", validOut, 1'b0);
    applyStimulus(0, 0, 0, 0, 64'd0, 0, 1, 32'hDEAD_BEEF, 0, 64'd0, 2'd0);
    tick();
    checkOutput("stale_valid", validOut, 1'b0);
    checkOutput("stale_instr", instruction, NOP);
    checkOutput("rd_req", imemReq, 1'b1);
    checkOutput("rd_new_addr", imemAddr, 64'h200);
    fetchOne(64'h200, 32'h3333_0001, 0, 64'd0, 2'd0);

    $display("[TB] decode stall across response");
    applyStimulus(0, 1, 0, 0, 64'd0, 1, 0, 32'd0, 0, 64'd0, 2'd0);
    checkOutput("st_addr", imemAddr, 64'h204);
    tick();
    checkOutput("st1_instr", instruction, 32'h3333_0001);
    applyStimulus(0, 1, 0, 0, 64'd0, 0, 1, 32'h3333_0002, 0, 64'd0, 2'd0);
    tick();
    checkOutput("st2_instr", instruction, 32'h3333_0001);
    checkOutput("st2_req", imemReq, 1'b0);
    applyStimulus(0, 1, 0, 0, 64'd0, 0, 0, 32'd0, 0, 64'd0, 2'd0);
    tick();
    checkOutput("st3_instr", instruction, 32'h3333_0001);
    checkOutput("st3_valid", validOut, 1'b1);
    applyStimulus(0, 0, 0, 0, 64'd0, 0, 0, 32'd0, 0, 64'd0, 2'd0);
    tick();
    checkOutput("rel_instr", instruction, 32'h3333_0002);
    checkOutput("rel_pc", pcOut, 64'h204);
    checkOutput("rel_valid", validOut, 1'b1);
    checkOutput("rel_addr", imemAddr, 64'h208);
    tick();
    checkOutput("once_valid", validOut, 1'b0);

    $display("[TB] flush with stall");
    fetchOne(64'h208, 32'h4444_0001, 0, 64'd0, 2'd0);
    applyStimulus(0, 1, 1, 0, 64'd0, 0, 0, 32'd0, 0, 64'd0, 2'd0);
    tick();
    checkOutput("fl_instr", instruction, NOP);
    checkOutput("fl_valid", validOut, 1'b0);

    $display("[TB] fetch stall gates request");
    applyStimulus(1, 0, 0, 0, 64'd0, 1, 0, 32'd0, 0, 64'd0, 2'd0);
    checkOutput("sf_req", imemReq, 1'b0);
    tick();
    applyStimulus(0, 0, 0, 0, 64'd0, 0, 0, 32'd0, 0, 64'd0, 2'd0);
    checkOutput("sf_req_after", imemReq, 1'b1);
    checkOutput("sf_addr", imemAddr, 64'h20C);

    $display("[TB] reset during wait");
    fetchOne(64'h20C, 32'h5555_0001, 0, 64'd0, 2'd0);
    applyStimulus(0, 1, 0, 0, 64'd0, 1, 0, 32'd0, 0, 64'd0, 2'd0);
    tick();
    checkOutput("pre_rst_valid", validOut, 1'b1);
    arstN = 1'b0;
    applyStimulus(0, 0, 0, 0, 64'd0, 0, 0, 32'd0, 0, 64'd0, 2'd0);
    checkOutput("mid_rst_valid", validOut, 1'b0);
    checkOutput("mid_rst_instr", instruction, NOP);
    checkOutput("mid_rst_pc", pcOut, 64'd0);
    checkOutput("mid_rst_req", imemReq, 1'b0);
    checkOutput("mid_rst_addr", imemAddr, 64'd0);
    tick();
    arstN = 1'b1;
    fetchOne(64'h0, 32'h6666_0001, 0, 64'd0, 2'd0);

    $display("[TB] PC wrap");
    applyStimulus(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 32'd0, 0, 64'd0, 2'd0);
    tick();
    fetchOne(64'hFFFF_FFFF_FFFF_FFFC, 32'h7777_0001, 0, 64'd0, 2'd0);
    checkOutput("wrap_addr", imemAddr, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
